seq_divider_6by3: RTL

Multi-cycle restoring divider: 6-bit dividend by 3-bit divisor, producing quotient and remainder.
- Inverse operation of the team's 3-bit combinational multiplier; shares its width conventions (3-bit operands, 6-bit product domain).
- Valid/ready handshake on both input and output, one operation in flight, one quotient bit resolved per clock.
- Sits beside the multiplier in the arithmetic mini-project set; used for round-trip (multiply then divide) checks.

---
 rtl/seq_divider_6by3.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/seq_divider_6by3.sv
// seq_divider_6by3: multi-cycle restoring divider, DW-bit dividend by SW-bit
// divisor, one quotient bit resolved per clock, MSB first.
// Optional feature macro: DIV_SELFCHECK_EN adds check_err, which flags a result
// whose quotient*divisor+remainder does not reproduce the captured dividend.
//
// Handshake: an input transfer happens on an edge where in_valid && in_ready;
// an output transfer happens on an edge where out_valid && out_ready. in_ready
// is high only in IDLE and out_valid only in DONE, so the two transfers can
// never fall on the same edge and only one operation is ever in flight.
module seq_divider_6by3 #(
  parameter int DW = 6,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [SW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [SW-1:0] remainder,
  output logic          div_by_zero,
`ifdef DIV_SELFCHECK_EN
  output logic          check_err,
`endif
  output logic [1:0]    dbg_state
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dsh_q, dsh_d;     // dividend bits shifting out, quotient bits shifting in
  logic [SW-1:0] dvs_q, dvs_d;     // captured divisor
  logic [SW:0]   prem_q, prem_d;   // partial remainder, one guard bit
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [SW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;
`ifdef DIV_SELFCHECK_EN
  logic [DW-1:0]    dvd_q, dvd_d;  // original dividend, kept for the self-check
  logic             chk_q, chk_d;
  logic [DW+SW-1:0] recon;
`endif

  logic          last_step;
  logic [SW:0]   shifted;
  logic [SW:0]   trial;
  logic          qbit;
  logic [SW:0]   step_rem;
  logic [DW-1:0] step_quot;

  assign last_step = (state_q == S_CALC) && (cnt_q == CW'(DW - 1));

  // State register and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dsh_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_SELFCHECK_EN
      dvd_q   <= '0;
      chk_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dsh_q   <= dsh_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SELFCHECK_EN
      dvd_q   <= dvd_d;
      chk_q   <= chk_d;
`endif
    end
  end

  // Next-state logic: divide-by-zero skips CALC and goes straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = (divisor == '0) ? S_DONE : S_CALC;
      S_CALC: if (last_step) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One restoring step: the guard bit of the trial difference is the borrow.
  always_comb begin
    shifted   = {prem_q[SW-1:0], dsh_q[DW-1]};
    trial     = shifted - {1'b0, dvs_q};
    qbit      = ~trial[SW];
    step_rem  = qbit ? trial : shifted;
    step_quot = {dsh_q[DW-2:0], qbit};
  end

`ifdef DIV_SELFCHECK_EN
  // Rebuild the dividend from the result about to be loaded.
  always_comb begin
    recon = (DW+SW)'(step_quot) * (DW+SW)'(dvs_q) + (DW+SW)'(step_rem[SW-1:0]);
  end
`endif

  // Datapath next values: capture on accept, shift in CALC, load result at the end.
  always_comb begin
    dsh_d  = dsh_q;
    dvs_d  = dvs_q;
    prem_d = prem_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
`ifdef DIV_SELFCHECK_EN
    dvd_d  = dvd_q;
    chk_d  = chk_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dsh_d  = dividend;
          dvs_d  = divisor;
          prem_d = '0;
          cnt_d  = '0;
`ifdef DIV_SELFCHECK_EN
          dvd_d  = dividend;
`endif
          if (divisor == '0) begin
            quot_d = '1;
            rem_d  = '0;
            dbz_d  = 1'b1;
`ifdef DIV_SELFCHECK_EN
            chk_d  = 1'b0;
`endif
          end
        end
      end
      S_CALC: begin
        dsh_d  = step_quot;
        prem_d = step_rem;
        cnt_d  = cnt_q + CW'(1);
        if (last_step) begin
          quot_d = step_quot;
          rem_d  = step_rem[SW-1:0];
          dbz_d  = 1'b0;
`ifdef DIV_SELFCHECK_EN
          chk_d  = (recon != (DW+SW)'(dvd_q));
`endif
        end
      end
      default: ;
    endcase
  end

  // Outputs: handshake flags decode the registered state, results come from registers.
  always_comb begin
    in_ready    = (state_q == S_IDLE);
    out_valid   = (state_q == S_DONE);
    quotient    = quot_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
`ifdef DIV_SELFCHECK_EN
    check_err   = chk_q;
`endif
    dbg_state   = state_q;
  end

endmodule
